// File: rtl/sram_controller_if.sv
// Memory-stage side of the SRAM bridge: request/handshake signals between the pipeline and the controller.
// The pipeline is the master and the controller is the slave.
interface sram_controller_if;
  logic        memoryReadEnabled;
  logic        memoryWriteEnabled;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (
    output memoryReadEnabled,
    output memoryWriteEnabled,
    output address,
    output writeData,
    input  readData,
    input  ready
  );

  modport slave (
    input  memoryReadEnabled,
    input  memoryWriteEnabled,
    input  address,
    input  writeData,
    output readData,
    output ready
  );
endinterface

// File: rtl/sram_controller.sv
// Bridges 32-bit pipeline loads/stores onto a 16-bit asynchronous SRAM as two timed half-word phases.
// ready stays low while an access is in flight so the pipeline freezes until DONE.
module sram_controller #(
  parameter int          SRAM_ADDR_WIDTH = 18,
  parameter int          WAIT_CYCLES     = 2,
  parameter logic [31:0] BASE_ADDR       = 32'd1024
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_controller_if.slave           bus,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic [15:0]                sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [15:0]                sram_dq_in
);

  localparam int WORD_W = SRAM_ADDR_WIDTH - 1;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [WORD_W-1:0]           word_reg, word_next;
  logic [15:0]                 wdata_hi_reg, wdata_hi_next;
  logic [31:0]                 rdata_reg, rdata_next;
  logic [SRAM_ADDR_WIDTH-1:0]  sram_addr_reg, sram_addr_next;
  logic                        we_n_reg, we_n_next;
  logic [15:0]                 dq_out_reg, dq_out_next;
  logic                        dq_oe_reg, dq_oe_next;

  logic [31:0]                 addr_diff;
  logic [WORD_W-1:0]           req_word;
  logic                        addr_unused;
  logic                        phase_end;

  // Word index is the byte offset from BASE_ADDR divided by four; offsets below the base wrap.
  assign addr_diff   = bus.address - BASE_ADDR;
  assign req_word    = addr_diff[SRAM_ADDR_WIDTH:2];
  assign addr_unused = ^{addr_diff[31:SRAM_ADDR_WIDTH+1], addr_diff[1:0]};
  assign phase_end   = (cnt_reg == CNT_LAST);

  assign bus.ready = ((state_reg == IDLE) && !bus.memoryReadEnabled && !bus.memoryWriteEnabled)
                     || (state_reg == DONE);
  assign bus.readData = rdata_reg;

  assign sram_addr   = sram_addr_reg;
  assign sram_we_n   = we_n_reg;
  assign sram_dq_out = dq_out_reg;
  assign sram_dq_oe  = dq_oe_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      word_reg      <= '0;
      wdata_hi_reg  <= '0;
      rdata_reg     <= '0;
      sram_addr_reg <= '0;
      we_n_reg      <= 1'b1;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      word_reg      <= word_next;
      wdata_hi_reg  <= wdata_hi_next;
      rdata_reg     <= rdata_next;
      sram_addr_reg <= sram_addr_next;
      we_n_reg      <= we_n_next;
      dq_out_reg    <= dq_out_next;
      dq_oe_reg     <= dq_oe_next;
    end
  end

  // SRAM pins are computed for the state being entered so they are registered and
  // already valid during the first cycle of each phase.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    word_next      = word_reg;
    wdata_hi_next  = wdata_hi_reg;
    rdata_next     = rdata_reg;
    sram_addr_next = sram_addr_reg;
    we_n_next      = 1'b1;
    dq_out_next    = dq_out_reg;
    dq_oe_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.memoryWriteEnabled) begin
          state_next     = WR_LO;
          cnt_next       = '0;
          word_next      = req_word;
          wdata_hi_next  = bus.writeData[31:16];
          sram_addr_next = {req_word, 1'b0};
          dq_out_next    = bus.writeData[15:0];
          we_n_next      = 1'b0;
          dq_oe_next     = 1'b1;
        end else if (bus.memoryReadEnabled) begin
          state_next     = RD_LO;
          cnt_next       = '0;
          word_next      = req_word;
          sram_addr_next = {req_word, 1'b0};
        end
      end

      WR_LO: begin
        we_n_next  = 1'b0;
        dq_oe_next = 1'b1;
        if (phase_end) begin
          state_next     = WR_HI;
          cnt_next       = '0;
          sram_addr_next = {word_reg, 1'b1};
          dq_out_next    = wdata_hi_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      WR_HI: begin
        // Strobe releases on the edge that enters DONE.
        if (phase_end) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          we_n_next  = 1'b0;
          dq_oe_next = 1'b1;
          cnt_next   = cnt_reg + CNT_W'(1);
        end
      end

      RD_LO: begin
        if (phase_end) begin
          state_next       = RD_HI;
          cnt_next         = '0;
          rdata_next[15:0] = sram_dq_in;
          sram_addr_next   = {word_reg, 1'b1};
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RD_HI: begin
        if (phase_end) begin
          state_next        = DONE;
          cnt_next          = '0;
          rdata_next[31:16] = sram_dq_in;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
